// File: rtl/qdr_arb_pkg.sv
// rtl/qdr_arb_pkg.sv - shared types and default widths for the QDR round-robin arbiter
package qdr_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int PID_W     = $clog2(NUM_PORTS);

    localparam int DEF_ADDR_W = 22;
    localparam int DEF_DATA_W = 36;
    localparam int DEF_BE_W   = 4;

    typedef logic [PID_W-1:0] port_id_t;

    // One-hot per-port vector for a port id.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_id_t id);
        logic [NUM_PORTS-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/qdr_arb_tag_fifo.sv
// rtl/qdr_arb_tag_fifo.sv - in-order FIFO of port ids for outstanding reads
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes the FIFO)
//   push, push_data write one port id
//   pop             drop the head entry
//   head            oldest port id
//   count           number of stored entries (0..DEPTH)
//   empty, full     status flags
module qdr_arb_tag_fifo
    import qdr_arb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = PID_W,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Self-protecting: overflowing pushes and underflowing pops are ignored.
    always_comb begin
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head  = mem[rd_ptr];
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
    end

endmodule

// File: rtl/qdr_rr_arbiter.sv
// rtl/qdr_rr_arbiter.sv - two-port round-robin arbiter onto one QDR sniffer master
//
// Optional feature macro: QDR_ARB_STATS_EN (adds per-port issued write/read counters).
//
// Ports:
//   qdr_clk, rst                 clock, synchronous active-high reset
//   phy_rdy, cal_fail            PHY status; grants only when phy_rdy & ~cal_fail
//   req_addr/req_wr_data/req_wr_be  per-port command fields, port p at [p*W +: W]
//   req_wr_strb, req_rd_strb     per-port requests, held until req_ack
//   req_ack                      one-cycle command-accepted pulse per port
//   rsp_rd_data, rsp_rd_dvld     returned read data (shared) and per-port valid
//   master_*                     command/return interface to the sniffer
//   rd_orphan_err                sticky: read data with no outstanding read
//   busy                         at least one read outstanding
//   stat_wr_cnt, stat_rd_cnt     (QDR_ARB_STATS_EN only) per-port 32-bit counters
module qdr_rr_arbiter
    import qdr_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DEF_BE_W,
    parameter int MAX_RD = 16
) (
    input  logic                          qdr_clk,
    input  logic                          rst,
    input  logic                          phy_rdy,
    input  logic                          cal_fail,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0]          req_wr_strb,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wr_data,
    input  logic [NUM_PORTS*BE_W-1:0]     req_wr_be,
    input  logic [NUM_PORTS-1:0]          req_rd_strb,
    output logic [NUM_PORTS-1:0]          req_ack,
    output logic [DATA_W-1:0]             rsp_rd_data,
    output logic [NUM_PORTS-1:0]          rsp_rd_dvld,
    output logic [ADDR_W-1:0]             master_addr,
    output logic                          master_wr_strb,
    output logic [DATA_W-1:0]             master_wr_data,
    output logic [BE_W-1:0]               master_wr_be,
    output logic                          master_rd_strb,
    input  logic [DATA_W-1:0]             master_rd_data,
    input  logic                          master_rd_dvld,
    output logic                          rd_orphan_err,
`ifdef QDR_ARB_STATS_EN
    output logic [NUM_PORTS*32-1:0]       stat_wr_cnt,
    output logic [NUM_PORTS*32-1:0]       stat_rd_cnt,
`endif
    output logic                          busy
);

    localparam int CW = $clog2(MAX_RD) + 1;

    // Arbitration
    logic                 arb_en;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_eff;
    logic                 fifo_empty;
    logic                 fifo_full;
    port_id_t             fifo_head;
    logic                 rd_room;
    logic [NUM_PORTS-1:0] eligible;
    logic                 grant_vld;
    port_id_t             grant_id;
    port_id_t             rr_ptr;
    port_id_t             issue_id;

    // Granted command fields
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic [BE_W-1:0]      sel_be;
    logic                 sel_wr;
    logic                 sel_rd;

    // Read return
    logic                 pop;

    always_comb begin
        arb_en = phy_rdy & ~cal_fail;
        // A read issued last cycle is pushed only at the end of this cycle,
        // so count it now or two back-to-back reads could overflow the FIFO.
        count_eff = fifo_count + CW'(master_rd_strb);
        rd_room   = ~fifo_full & (count_eff < CW'(MAX_RD));
        for (int p = 0; p < NUM_PORTS; p++) begin
            // req_ack[p] high means p was granted last cycle and its strobe
            // is still the old, already-issued request.
            eligible[p] = arb_en
                        & (req_wr_strb[p] | req_rd_strb[p])
                        & ~req_ack[p]
                        & (~req_rd_strb[p] | rd_room);
        end
        grant_vld = |eligible;
        if (&eligible) begin
            grant_id = rr_ptr;
        end else begin
            grant_id = port_id_t'(eligible[1]);
        end
    end

    always_comb begin
        sel_addr = req_addr[ADDR_W-1:0];
        sel_data = req_wr_data[DATA_W-1:0];
        sel_be   = req_wr_be[BE_W-1:0];
        sel_wr   = req_wr_strb[0];
        sel_rd   = req_rd_strb[0];
        if (grant_id == port_id_t'(1)) begin
            sel_addr = req_addr[2*ADDR_W-1:ADDR_W];
            sel_data = req_wr_data[2*DATA_W-1:DATA_W];
            sel_be   = req_wr_be[2*BE_W-1:BE_W];
            sel_wr   = req_wr_strb[1];
            sel_rd   = req_rd_strb[1];
        end
    end

    // Command issue: everything registered, one-cycle latency from grant.
    always_ff @(posedge qdr_clk) begin
        if (rst) begin
            req_ack        <= '0;
            master_addr    <= '0;
            master_wr_strb <= 1'b0;
            master_wr_data <= '0;
            master_wr_be   <= '0;
            master_rd_strb <= 1'b0;
            rr_ptr         <= '0;
            issue_id       <= '0;
        end else begin
            req_ack        <= '0;
            master_wr_strb <= 1'b0;
            master_rd_strb <= 1'b0;
            if (grant_vld) begin
                req_ack        <= port_onehot(grant_id);
                master_addr    <= sel_addr;
                master_wr_data <= sel_data;
                master_wr_be   <= sel_be;
                master_wr_strb <= sel_wr;
                master_rd_strb <= sel_rd;
                rr_ptr         <= ~grant_id;
                issue_id       <= grant_id;
            end
        end
    end

    // The issued read strobe pushes the port id that issued it.
    qdr_arb_tag_fifo #(
        .DEPTH (MAX_RD),
        .W     (PID_W),
        .CW    (CW)
    ) u_tag_fifo (
        .clk       (qdr_clk),
        .rst       (rst),
        .push      (master_rd_strb),
        .push_data (issue_id),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        pop  = master_rd_dvld & ~fifo_empty;
        busy = ~fifo_empty;
    end

    // Read return steering; data arriving with nothing outstanding is dropped.
    always_ff @(posedge qdr_clk) begin
        if (rst) begin
            rsp_rd_data   <= '0;
            rsp_rd_dvld   <= '0;
            rd_orphan_err <= 1'b0;
        end else begin
            rsp_rd_dvld <= '0;
            if (master_rd_dvld) begin
                rsp_rd_data <= master_rd_data;
            end
            if (pop) begin
                rsp_rd_dvld <= port_onehot(fifo_head);
            end
            if (master_rd_dvld && fifo_empty) begin
                rd_orphan_err <= 1'b1;
            end
        end
    end

`ifdef QDR_ARB_STATS_EN
    logic [31:0] wr_cnt [NUM_PORTS];
    logic [31:0] rd_cnt [NUM_PORTS];

    always_ff @(posedge qdr_clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_cnt[p] <= '0;
                rd_cnt[p] <= '0;
            end
        end else if (grant_vld) begin
            if (sel_wr) begin
                wr_cnt[grant_id] <= wr_cnt[grant_id] + 32'd1;
            end
            if (sel_rd) begin
                rd_cnt[grant_id] <= rd_cnt[grant_id] + 32'd1;
            end
        end
    end

    always_comb begin
        stat_wr_cnt = {wr_cnt[1], wr_cnt[0]};
        stat_rd_cnt = {rd_cnt[1], rd_cnt[0]};
    end
`endif

endmodule

// File: tb/tb_qdr_rr_arbiter.sv
// tb/tb_qdr_rr_arbiter.sv - self-checking bench for qdr_rr_arbiter
module tb_qdr_rr_arbiter;

    localparam int AW = 22;
    localparam int DW = 36;
    localparam int BW = 4;

    logic          qdr_clk;
    logic          rst;
    logic          phy_rdy;
    logic          cal_fail;
    logic [2*AW-1:0] req_addr;
    logic [1:0]    req_wr_strb;
    logic [2*DW-1:0] req_wr_data;
    logic [2*BW-1:0] req_wr_be;
    logic [1:0]    req_rd_strb;
    logic [1:0]    req_ack;
    logic [DW-1:0] rsp_rd_data;
    logic [1:0]    rsp_rd_dvld;
    logic [AW-1:0] master_addr;
    logic          master_wr_strb;
    logic [DW-1:0] master_wr_data;
    logic [BW-1:0] master_wr_be;
    logic          master_rd_strb;
    logic [DW-1:0] master_rd_data;
    logic          master_rd_dvld;
    logic          rd_orphan_err;
    logic          busy;
`ifdef QDR_ARB_STATS_EN
    logic [63:0]   stat_wr_cnt;
    logic [63:0]   stat_rd_cnt;
`endif

    qdr_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .MAX_RD(16)) dut (
        .qdr_clk        (qdr_clk),
        .rst            (rst),
        .phy_rdy        (phy_rdy),
        .cal_fail       (cal_fail),
        .req_addr       (req_addr),
        .req_wr_strb    (req_wr_strb),
        .req_wr_data    (req_wr_data),
        .req_wr_be      (req_wr_be),
        .req_rd_strb    (req_rd_strb),
        .req_ack        (req_ack),
        .rsp_rd_data    (rsp_rd_data),
        .rsp_rd_dvld    (rsp_rd_dvld),
        .master_addr    (master_addr),
        .master_wr_strb (master_wr_strb),
        .master_wr_data (master_wr_data),
        .master_wr_be   (master_wr_be),
        .master_rd_strb (master_rd_strb),
        .master_rd_data (master_rd_data),
        .master_rd_dvld (master_rd_dvld),
        .rd_orphan_err  (rd_orphan_err),
`ifdef QDR_ARB_STATS_EN
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_rd_cnt    (stat_rd_cnt),
`endif
        .busy           (busy)
    );

    initial qdr_clk = 1'b0;
    always #5 qdr_clk = ~qdr_clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        phy_rdy        = 1'b0;
        cal_fail       = 1'b0;
        req_addr       = '0;
        req_wr_strb    = '0;
        req_wr_data    = '0;
        req_wr_be      = '0;
        req_rd_strb    = '0;
        master_rd_data = '0;
        master_rd_dvld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge qdr_clk);
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge qdr_clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        phy;
        logic        cal;
        logic [1:0]  wr;
        logic [1:0]  rd;
        logic [1:0]  exp_ack;
        logic        exp_mwr;
        logic        exp_mrd;
        logic [21:0] exp_addr;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs [8];

    // Both ports read continuously from reset; sniffer returns data = addr.
    task automatic two_port_reads();
        int c0, c1, r0, r1;
        logic [21:0] q[$];
        int order[$];
        do_reset();
        phy_rdy          = 1'b1;
        req_addr[21:0]   = 22'h10;
        req_addr[43:22]  = 22'h20;
        req_rd_strb      = 2'b11;
        c0 = 0; c1 = 0; r0 = 0; r1 = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge qdr_clk);
            if (rsp_rd_dvld[0]) begin
                chk("p0_rd_data", 64'(rsp_rd_data), 64'(22'h10 + 22'(r0)));
                r0++;
            end
            if (rsp_rd_dvld[1]) begin
                chk("p1_rd_data", 64'(rsp_rd_data), 64'(22'h20 + 22'(r1)));
                r1++;
            end
            if (req_ack[0]) begin
                order.push_back(0);
                c0++;
                if (c0 == 4) req_rd_strb[0] = 1'b0;
                else req_addr[21:0] = 22'h10 + 22'(c0);
            end
            if (req_ack[1]) begin
                order.push_back(1);
                c1++;
                if (c1 == 4) req_rd_strb[1] = 1'b0;
                else req_addr[43:22] = 22'h20 + 22'(c1);
            end
            // Return only reads seen on an earlier cycle (already pushed).
            if (q.size() > 0) begin
                master_rd_dvld = 1'b1;
                master_rd_data = DW'(q.pop_front());
            end else begin
                master_rd_dvld = 1'b0;
            end
            if (master_rd_strb) q.push_back(master_addr);
        end
        chk("grant_count", 64'(order.size()), 64'd8);
        for (int i = 0; i < order.size() && i < 8; i++) begin
            chk("grant_order", 64'(order[i]), 64'(i % 2));
        end
        chk("p0_returns", 64'(r0), 64'd4);
        chk("p1_returns", 64'(r1), 64'd4);
        chk("no_orphan", 64'(rd_orphan_err), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        logic got0, got1, any_rsp, bad;

        rst = 1'b1;
        clear_inputs();

        // phy, cal, wr, rd, ack, mwr, mrd, addr, be  (port0 addr AB be 3, port1 addr CD be C)
        vecs[0] = '{1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 22'h0,  4'h0};
        vecs[1] = '{1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 22'h0,  4'h0};
        vecs[2] = '{1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0, 22'hAB, 4'h3};
        vecs[3] = '{1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 22'hCD, 4'hC};
        vecs[4] = '{1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 22'hAB, 4'h3};
        vecs[5] = '{1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 1'b1, 1'b1, 22'hCD, 4'hC};
        vecs[6] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 22'h0,  4'h0};
        vecs[7] = '{1'b1, 1'b0, 2'b00, 2'b11, 2'b01, 1'b0, 1'b1, 22'hAB, 4'h3};

        do_reset();
        chk("rst_ack",     64'(req_ack), 64'd0);
        chk("rst_strobes", 64'({master_wr_strb, master_rd_strb}), 64'd0);
        chk("rst_addr",    64'(master_addr), 64'd0);
        chk("rst_rsp",     64'(rsp_rd_dvld), 64'd0);
        chk("rst_flags",   64'({rd_orphan_err, busy}), 64'd0);

        // Single-cycle arbitration vectors, each from a fresh reset.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            phy_rdy         = vecs[i].phy;
            cal_fail        = vecs[i].cal;
            req_addr        = {22'hCD, 22'hAB};
            req_wr_be       = 8'hC3;
            req_wr_data     = {36'h2_2222_2222, 36'h1_1111_1111};
            req_wr_strb     = vecs[i].wr;
            req_rd_strb     = vecs[i].rd;
            @(negedge qdr_clk);
            chk($sformatf("vec%0d_ack", i), 64'(req_ack), 64'(vecs[i].exp_ack));
            chk($sformatf("vec%0d_mwr", i), 64'(master_wr_strb), 64'(vecs[i].exp_mwr));
            chk($sformatf("vec%0d_mrd", i), 64'(master_rd_strb), 64'(vecs[i].exp_mrd));
            chk($sformatf("vec%0d_addr", i), 64'(master_addr), 64'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_be", i), 64'(master_wr_be), 64'(vecs[i].exp_be));
        end

        // 1: PHY not ready blocks a held write, then it goes out 1 cycle after phy_rdy.
        do_reset();
        req_addr[21:0] = 22'h0000AB;
        req_wr_strb    = 2'b01;
        bad = 1'b0;
        repeat (10) begin
            @(negedge qdr_clk);
            if (req_ack != 2'b00 || master_wr_strb) bad = 1'b1;
        end
        chk("phy_low_blocks", 64'(bad), 64'd0);
        phy_rdy = 1'b1;
        @(negedge qdr_clk);
        chk("phy_up_ack",  64'(req_ack), 64'd1);
        chk("phy_up_mwr",  64'(master_wr_strb), 64'd1);
        chk("phy_up_addr", 64'(master_addr), 64'h0000AB);
        req_wr_strb = 2'b00;
        @(negedge qdr_clk);
        chk("ack_single_pulse", 64'({req_ack, master_wr_strb}), 64'd0);

        // 2: alternating two-port reads with in-order return steering.
        two_port_reads();

        // 3: FIFO full blocks reads but not writes; one return frees a slot.
        do_reset();
        phy_rdy        = 1'b1;
        req_addr[21:0] = 22'h100;
        req_rd_strb    = 2'b01;
        n = 0;
        for (int cyc = 0; cyc < 80 && n < 16; cyc++) begin
            @(negedge qdr_clk);
            if (req_ack[0]) begin
                n++;
                req_addr[21:0] = 22'h100 + 22'(n);
            end
        end
        chk("fill_acks", 64'(n), 64'd16);
        req_addr[43:22] = 22'h3FF;
        req_wr_strb     = 2'b10;
        got0 = 1'b0;
        got1 = 1'b0;
        repeat (6) begin
            @(negedge qdr_clk);
            if (req_ack[0]) got0 = 1'b1;
            if (req_ack[1]) begin
                got1 = 1'b1;
                req_wr_strb = 2'b00;
            end
        end
        chk("full_blocks_read", 64'(got0), 64'd0);
        chk("full_write_acked", 64'(got1), 64'd1);
        chk("full_busy",        64'(busy), 64'd1);
        master_rd_dvld = 1'b1;
        master_rd_data = 36'h9_8765_4321;
        @(negedge qdr_clk);
        master_rd_dvld = 1'b0;
        chk("full_ret_dvld", 64'(rsp_rd_dvld), 64'd1);
        chk("full_ret_data", 64'(rsp_rd_data), 64'h9_8765_4321);
        got0 = 1'b0;
        for (int k = 0; k < 5 && !got0; k++) begin
            @(negedge qdr_clk);
            if (req_ack[0]) got0 = 1'b1;
        end
        req_rd_strb = 2'b00;
        chk("slot_freed_ack", 64'(got0), 64'd1);

        // 4: orphan read data.
        do_reset();
        master_rd_dvld = 1'b1;
        master_rd_data = 36'h5;
        @(negedge qdr_clk);
        master_rd_dvld = 1'b0;
        chk("orphan_no_dvld", 64'(rsp_rd_dvld), 64'd0);
        chk("orphan_set",     64'(rd_orphan_err), 64'd1);
        repeat (5) @(negedge qdr_clk);
        chk("orphan_sticky",  64'(rd_orphan_err), 64'd1);
        do_reset();
        chk("orphan_cleared", 64'(rd_orphan_err), 64'd0);

        // 5: reset with reads in flight; late returns become orphans.
        do_reset();
        phy_rdy        = 1'b1;
        req_addr[21:0] = 22'h1;
        req_rd_strb    = 2'b01;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            @(negedge qdr_clk);
            if (req_ack[0]) begin
                n++;
                req_addr[21:0] = 22'h1 + 22'(n);
                if (n == 3) req_rd_strb = 2'b00;
            end
        end
        chk("inflight_acks", 64'(n), 64'd3);
        @(negedge qdr_clk);
        chk("inflight_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge qdr_clk);
        rst = 1'b0;
        chk("rst_mid_strobes", 64'({master_wr_strb, master_rd_strb}), 64'd0);
        chk("rst_mid_flushed", 64'(busy), 64'd0);
        any_rsp = 1'b0;
        repeat (3) begin
            master_rd_dvld = 1'b1;
            @(negedge qdr_clk);
            master_rd_dvld = 1'b0;
            if (rsp_rd_dvld != 2'b00) any_rsp = 1'b1;
        end
        @(negedge qdr_clk);
        if (rsp_rd_dvld != 2'b00) any_rsp = 1'b1;
        chk("late_no_dvld",  64'(any_rsp), 64'd0);
        chk("late_orphan",   64'(rd_orphan_err), 64'd1);
        chk("late_count0",   64'(busy), 64'd0);

`ifdef QDR_ARB_STATS_EN
        // 6: statistics counters and 32-bit wrap.
        two_port_reads();
        chk("stat_rd", stat_rd_cnt, {32'd4, 32'd4});
        chk("stat_wr", stat_wr_cnt, 64'd0);
        @(negedge qdr_clk);
        force dut.wr_cnt[0] = 32'hFFFF_FFFF;
        @(negedge qdr_clk);
        release dut.wr_cnt[0];
        req_wr_strb = 2'b01;
        @(negedge qdr_clk);
        req_wr_strb = 2'b00;
        chk("stat_wrap_ack", 64'(req_ack), 64'd1);
        chk("stat_wrap",     64'(stat_wr_cnt[31:0]), 64'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
